mux2_rr_arbiter: RTL

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

---
 rtl/mux2_rr_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// Module   : mux2_rr_arbiter
// Brief    : Two-source round-robin arbiter feeding a registered output stage
//            that supplies payload and select for a downstream 2:1 mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel
);

  localparam logic c_SRC_A = 1'b0;
  localparam logic c_SRC_B = 1'b1;

  localparam logic [0:0] c_EMPTY = 1'b0;
  localparam logic [0:0] c_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_y_data;
  logic             r_sel;
  logic             r_last_grant;

  logic             w_ld;
  logic             w_grant_vld;
  logic             w_grant_src;
  logic             w_take;

  assign w_ld        = (r_state == c_EMPTY) || y_ready;
  assign w_grant_vld = a_valid || b_valid;

  // On contention the source that did not win last time takes its turn.
  always_comb begin
    w_grant_src = c_SRC_A;
    if (a_valid && b_valid) begin
      w_grant_src = ~r_last_grant;
    end else if (b_valid) begin
      w_grant_src = c_SRC_B;
    end
  end

  assign w_take  = !rst && w_ld && w_grant_vld;
  assign a_ready = w_take && (w_grant_src == c_SRC_A);
  assign b_ready = w_take && (w_grant_src == c_SRC_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_EMPTY;
      r_y_data     <= '0;
      r_sel        <= c_SRC_A;
      r_last_grant <= c_SRC_B;
    end else if (w_ld) begin
      if (w_grant_vld) begin
        r_state      <= c_FULL;
        r_y_data     <= (w_grant_src == c_SRC_B) ? b_data : a_data;
        r_sel        <= w_grant_src;
        r_last_grant <= w_grant_src;
      end else begin
        r_state      <= c_EMPTY;
      end
    end
  end

  assign y_data  = r_y_data;
  assign y_valid = (r_state == c_FULL);
  assign sel     = r_sel;

endmodule

`default_nettype wire
